// File: rtl/aes_mode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_mode_pkg
// Purpose  : Shared encodings for the streaming AES mode engine: chaining
//            mode codes, FSM states and the default block width.
// Revision : 1.0 - initial release
// ============================================================================
package aes_mode_pkg;

   localparam int unsigned DATA_W_DEF = 128;

   localparam logic [2:0] MODE_ECB = 3'd0;
   localparam logic [2:0] MODE_CBC = 3'd1;
   localparam logic [2:0] MODE_CFB = 3'd2;
   localparam logic [2:0] MODE_OFB = 3'd3;
   localparam logic [2:0] MODE_CTR = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_CORE   = 2'd2,
      ST_OUTPUT = 2'd3
   } state_e;

   // Codes 5..7 are reserved and rejected at message start.
   function automatic logic mode_is_valid(input logic [2:0] mode);
      return (mode <= MODE_CTR);
   endfunction

   // Only ECB and CBC run the core in the requested direction; the stream
   // modes always use the forward cipher as a keystream generator.
   function automatic logic mode_uses_dir(input logic [2:0] mode);
      return (mode == MODE_ECB) || (mode == MODE_CBC);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_chain_unit.sv
`default_nettype none
// ============================================================================
// Module   : aes_chain_unit
// Purpose  : Chaining register (IV / feedback / counter) with the per-mode
//            core-input and result selection around the AES core.
// Revision : 1.0 - initial release
// ============================================================================
module aes_chain_unit
   import aes_mode_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CTR_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_iv_i,
   input  logic [DATA_W-1:0] iv_i,
   input  logic              update_i,
   input  logic [2:0]        mode_i,
   input  logic              enc_i,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic [DATA_W-1:0] blk_i,
   input  logic [DATA_W-1:0] core_out_i,
   output logic [DATA_W-1:0] core_in_o,
   output logic [DATA_W-1:0] out_o
);

   logic [DATA_W-1:0] chain_q;
   logic [DATA_W-1:0] chain_d;
   logic [DATA_W-1:0] ctr_next;

   // Counter increment wraps inside the low CTR_W bits only.
   generate
      if (CTR_W >= DATA_W) begin : g_ctr_full
         assign ctr_next = chain_q + DATA_W'(1);
      end else begin : g_ctr_part
         assign ctr_next = {chain_q[DATA_W-1:CTR_W], chain_q[CTR_W-1:0] + CTR_W'(1)};
      end
   endgenerate

   // Core input from the incoming block, result from the core output, and
   // the next chain value, all selected by the latched mode.
   always_comb begin
      core_in_o = chain_q;
      out_o     = core_out_i ^ blk_i;
      chain_d   = chain_q;
      case (mode_i)
         MODE_ECB: begin
            core_in_o = s_data_i;
            out_o     = core_out_i;
         end
         MODE_CBC: begin
            if (enc_i) begin
               core_in_o = s_data_i ^ chain_q;
               out_o     = core_out_i;
               chain_d   = core_out_i;
            end else begin
               core_in_o = s_data_i;
               out_o     = core_out_i ^ chain_q;
               chain_d   = blk_i;
            end
         end
         MODE_CFB: chain_d = enc_i ? (core_out_i ^ blk_i) : blk_i;
         MODE_OFB: chain_d = core_out_i;
         MODE_CTR: chain_d = ctr_next;
         default:  chain_d = chain_q;
      endcase
   end

   // Chain register: IV load at message start, update on core completion.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= '0;
      end else if (load_iv_i) begin
         chain_q <= iv_i;
      end else if (update_i) begin
         chain_q <= chain_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/aes_stream_mode_engine.sv
`default_nettype none
// ============================================================================
// Module   : aes_stream_mode_engine
// Purpose  : Multi-block ECB/CBC/CFB/OFB/CTR engine between a valid/ready
//            block stream and an external start/done AES core.
// Revision : 1.0 - initial release
// ============================================================================
module aes_stream_mode_engine
   import aes_mode_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CTR_W  = 32,
   parameter int unsigned LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic [2:0]        cfg_mode,
   input  logic              cfg_enc_dec,
   input  logic [DATA_W-1:0] cfg_iv,
   input  logic [LEN_W-1:0]  cfg_num_blocks,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              core_start,
   output logic              core_enc_dec,
   output logic [DATA_W-1:0] core_in,
   input  logic [DATA_W-1:0] core_out,
   input  logic              core_done,
   output logic              busy,
   output logic              msg_done,
   output logic              err_mode
);

   state_e             state_q;
   logic [2:0]         mode_q;
   logic               enc_q;
   logic [LEN_W-1:0]   remaining_q;
   logic [DATA_W-1:0]  blk_q;
   logic [DATA_W-1:0]  core_in_q;
   logic [DATA_W-1:0]  m_data_q;
   logic               s_ready_q, m_valid_q, m_last_q, core_start_q;
   logic               core_enc_dec_q, busy_q, msg_done_q, err_mode_q;
   logic [DATA_W-1:0]  core_in_d;
   logic [DATA_W-1:0]  out_d;
   logic               load_iv, chain_update;

   assign load_iv      = (state_q == ST_IDLE) && cfg_start && mode_is_valid(cfg_mode);
   assign chain_update = (state_q == ST_CORE) && core_done;

   aes_chain_unit #(
      .DATA_W (DATA_W),
      .CTR_W  (CTR_W)
   ) u_chain (
      .clk_i      (clk),
      .rst_ni     (reset),
      .load_iv_i  (load_iv),
      .iv_i       (cfg_iv),
      .update_i   (chain_update),
      .mode_i     (mode_q),
      .enc_i      (enc_q),
      .s_data_i   (s_data),
      .blk_i      (blk_q),
      .core_out_i (core_out),
      .core_in_o  (core_in_d),
      .out_o      (out_d)
   );

   // Message control FSM with registered handshake and status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         mode_q         <= MODE_ECB;
         enc_q          <= 1'b0;
         remaining_q    <= '0;
         blk_q          <= '0;
         core_in_q      <= '0;
         m_data_q       <= '0;
         s_ready_q      <= 1'b0;
         m_valid_q      <= 1'b0;
         m_last_q       <= 1'b0;
         core_start_q   <= 1'b0;
         core_enc_dec_q <= 1'b0;
         busy_q         <= 1'b0;
         msg_done_q     <= 1'b0;
         err_mode_q     <= 1'b0;
      end else begin
         core_start_q <= 1'b0;
         msg_done_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cfg_start) begin
                  if (!mode_is_valid(cfg_mode)) begin
                     err_mode_q <= 1'b1;
                  end else begin
                     err_mode_q     <= 1'b0;
                     mode_q         <= cfg_mode;
                     enc_q          <= cfg_enc_dec;
                     remaining_q    <= cfg_num_blocks;
                     core_enc_dec_q <= mode_uses_dir(cfg_mode) ? cfg_enc_dec : 1'b1;
                     if (cfg_num_blocks == '0) begin
                        msg_done_q <= 1'b1;
                     end else begin
                        busy_q    <= 1'b1;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_ACCEPT;
                     end
                  end
               end
            end
            ST_ACCEPT: begin
               if (s_valid) begin
                  s_ready_q    <= 1'b0;
                  blk_q        <= s_data;
                  core_in_q    <= core_in_d;
                  core_start_q <= 1'b1;
                  state_q      <= ST_CORE;
               end
            end
            ST_CORE: begin
               if (core_done) begin
                  m_data_q  <= out_d;
                  m_valid_q <= 1'b1;
                  m_last_q  <= (remaining_q == LEN_W'(1));
                  state_q   <= ST_OUTPUT;
               end
            end
            ST_OUTPUT: begin
               if (m_ready) begin
                  m_valid_q   <= 1'b0;
                  m_last_q    <= 1'b0;
                  remaining_q <= remaining_q - LEN_W'(1);
                  if (remaining_q == LEN_W'(1)) begin
                     msg_done_q <= 1'b1;
                     busy_q     <= 1'b0;
                     state_q    <= ST_IDLE;
                  end else begin
                     s_ready_q <= 1'b1;
                     state_q   <= ST_ACCEPT;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_ready      = s_ready_q;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_last       = m_last_q;
   assign core_start   = core_start_q;
   assign core_enc_dec = core_enc_dec_q;
   assign core_in      = core_in_q;
   assign busy         = busy_q;
   assign msg_done     = msg_done_q;
   assign err_mode     = err_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_stream_mode_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_stream_mode_engine
// Purpose  : Self-checking bench for aes_stream_mode_engine with an XOR
//            stand-in for the AES core and a mode-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_stream_mode_engine;

   localparam int unsigned DW = 128;
   localparam logic [DW-1:0] ONES = {DW{1'b1}};

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cfg_start = 1'b0;
   logic [2:0]    cfg_mode = 3'd0;
   logic          cfg_enc_dec = 1'b0;
   logic [DW-1:0] cfg_iv = '0;
   logic [15:0]   cfg_num_blocks = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          core_start;
   logic          core_enc_dec;
   logic [DW-1:0] core_in;
   logic [DW-1:0] core_out = '0;
   logic          core_done = 1'b0;
   logic          busy;
   logic          msg_done;
   logic          err_mode;

   int n_assert = 0;
   int n_fail   = 0;

   logic [DW-1:0] din     [0:7];
   logic [DW-1:0] got_out [0:7];
   logic [DW-1:0] got_cin [0:7];
   logic          got_last[0:7];
   logic [DW-1:0] exp_out [0:7];
   logic [DW-1:0] exp_cin [0:7];
   logic [DW-1:0] pt      [0:7];

   aes_stream_mode_engine #(.DATA_W(128), .CTR_W(32), .LEN_W(16)) dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
      .cfg_enc_dec(cfg_enc_dec), .cfg_iv(cfg_iv), .cfg_num_blocks(cfg_num_blocks),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .core_start(core_start), .core_enc_dec(core_enc_dec), .core_in(core_in),
      .core_out(core_out), .core_done(core_done),
      .busy(busy), .msg_done(msg_done), .err_mode(err_mode)
   );

   always #5 clk = ~clk;

   // Stand-in core: E = in ^ all-ones, done two cycles after start.
   // A pending job is deliberately not cancelled by reset.
   int            core_pend = 0;
   logic [DW-1:0] core_lat  = '0;
   always @(negedge clk) begin
      core_done = 1'b0;
      if (core_pend > 0) begin
         core_pend = core_pend - 1;
         if (core_pend == 0) begin
            core_done = 1'b1;
            core_out  = core_lat ^ ONES;
         end
      end
      if (core_start) begin
         core_pend = 2;
         core_lat  = core_in;
      end
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Mode-level reference: expected core inputs and results for a message.
   task automatic model_run(input logic [2:0] mode, input logic enc,
                            input logic [DW-1:0] iv, input int n);
      logic [DW-1:0] chain, d, ci, e, o;
      chain = iv;
      for (int i = 0; i < n; i++) begin
         d = din[i];
         case (mode)
            3'd0: begin ci = d; e = ~ci; o = e; end
            3'd1: begin
               if (enc) begin ci = d ^ chain; e = ~ci; o = e; chain = o; end
               else     begin ci = d; e = ~ci; o = e ^ chain; chain = d; end
            end
            3'd2: begin ci = chain; e = ~ci; o = e ^ d; chain = enc ? o : d; end
            3'd3: begin ci = chain; e = ~ci; o = e ^ d; chain = e; end
            default: begin
               ci = chain; e = ~ci; o = e ^ d;
               chain[31:0] = chain[31:0] + 32'd1;
            end
         endcase
         exp_cin[i] = ci;
         exp_out[i] = o;
      end
   endtask

   // Drives one whole message; bp adds a stall with a stray cfg_start on block 0.
   task automatic run_msg(input logic [2:0] mode, input logic enc,
                          input logic [DW-1:0] iv, input int n, input bit bp);
      int t;
      logic [DW-1:0] hold;
      logic exp_dir;
      exp_dir = (mode <= 3'd1) ? enc : 1'b1;
      @(negedge clk);
      cfg_mode = mode; cfg_enc_dec = enc; cfg_iv = iv;
      cfg_num_blocks = 16'(n); cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check("busy_after_start", busy, 1);
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (!s_ready && t < 100) begin @(negedge clk); t++; end
         check("s_ready_wait", s_ready, 1);
         s_valid = 1'b1; s_data = din[i];
         @(negedge clk);
         s_valid = 1'b0;
         check("core_start_pulse", core_start, 1);
         check("core_enc_dec", core_enc_dec, exp_dir);
         got_cin[i] = core_in;
         t = 0;
         while (!m_valid && t < 100) begin @(negedge clk); t++; end
         check("m_valid_wait", m_valid, 1);
         if (bp && i == 0) begin
            hold = m_data;
            cfg_mode = 3'd0; cfg_iv = ~iv; cfg_start = 1'b1;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               cfg_start = 1'b0;
               check("bp_m_valid", m_valid, 1);
               check("bp_m_data", m_data, hold);
               check("bp_s_ready", s_ready, 0);
               check("bp_core_start", core_start, 0);
            end
         end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         got_out[i] = m_data; got_last[i] = m_last;
         m_ready = 1'b1;
         @(negedge clk);
         m_ready = 1'b0;
         check("m_valid_drop", m_valid, 0);
         check("msg_done_edge", msg_done, (i == n - 1) ? 1 : 0);
         if (i == n - 1) check("busy_end", busy, 0);
      end
      @(negedge clk);
      check("msg_done_single", msg_done, 0);
   endtask

   task automatic compare_model(input logic [2:0] mode, input logic enc,
                                input logic [DW-1:0] iv, input int n);
      model_run(mode, enc, iv, n);
      for (int i = 0; i < n; i++) begin
         check("model_core_in", got_cin[i], exp_cin[i]);
         check("model_m_data", got_out[i], exp_out[i]);
         check("model_m_last", got_last[i], (i == n - 1) ? 1 : 0);
      end
   endtask

   initial begin
      logic [2:0]    md;
      logic          en;
      logic [DW-1:0] iv;
      int            n;

      // Reset state
      #1;
      check("reset_outputs", {s_ready, m_valid, m_data, m_last, core_start,
                              core_enc_dec, core_in, busy, msg_done, err_mode}, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // ECB encrypt, single zero block
      din[0] = '0;
      run_msg(3'd0, 1'b1, '0, 1, 1'b0);
      check("ecb_m_data", got_out[0], ONES);
      check("ecb_m_last", got_last[0], 1);
      compare_model(3'd0, 1'b1, '0, 1);

      // CBC encrypt then decrypt of two zero blocks, iv = 1
      din[0] = '0; din[1] = '0;
      run_msg(3'd1, 1'b1, DW'(1), 2, 1'b0);
      check("cbc_enc_blk0", got_out[0], {ONES[DW-1:1], 1'b0});
      check("cbc_enc_blk1", got_out[1], DW'(1));
      compare_model(3'd1, 1'b1, DW'(1), 2);
      din[0] = got_out[0]; din[1] = got_out[1];
      run_msg(3'd1, 1'b0, DW'(1), 2, 1'b0);
      check("cbc_dec_blk0", got_out[0], '0);
      check("cbc_dec_blk1", got_out[1], '0);

      // CTR wrap stays inside the low 32 bits
      din[0] = rnd128(); din[1] = rnd128();
      run_msg(3'd4, 1'b0, 128'h1_FFFFFFFF, 2, 1'b0);
      check("ctr_core_in0", got_cin[0], 128'h1_FFFFFFFF);
      check("ctr_core_in1", got_cin[1], 128'h1_00000000);
      compare_model(3'd4, 1'b0, 128'h1_FFFFFFFF, 2);

      // Output backpressure with a stray cfg_start while busy
      iv = rnd128();
      for (int i = 0; i < 3; i++) din[i] = rnd128();
      run_msg(3'd2, 1'b1, iv, 3, 1'b1);
      compare_model(3'd2, 1'b1, iv, 3);

      // Invalid mode
      @(negedge clk);
      cfg_mode = 3'd6; cfg_num_blocks = 16'd3; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check("err_mode_set", err_mode, 1);
      check("err_busy", busy, 0);
      check("err_s_ready", s_ready, 0);

      // Zero-length message
      cfg_mode = 3'd0; cfg_num_blocks = '0; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check("zero_msg_done", msg_done, 1);
      check("zero_busy", busy, 0);
      check("zero_s_ready", s_ready, 0);
      check("err_cleared", err_mode, 0);
      @(negedge clk);
      check("zero_msg_done_pulse", msg_done, 0);

      // Reset while the core is working
      cfg_mode = 3'd1; cfg_enc_dec = 1'b1; cfg_iv = rnd128();
      cfg_num_blocks = 16'd2; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      s_valid = 1'b1; s_data = rnd128();
      @(negedge clk);
      s_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("midreset_outputs", {s_ready, m_valid, m_data, m_last, core_start,
                                 core_enc_dec, core_in, busy, msg_done, err_mode}, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("late_done_ignored", {m_valid, busy, s_ready}, 0);
      end

      // Randomised messages: model check, then round trip back to plaintext
      for (int r = 0; r < 6; r++) begin
         md = 3'($urandom_range(0, 4));
         en = 1'($urandom_range(0, 1));
         iv = rnd128();
         n  = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin din[i] = rnd128(); pt[i] = din[i]; end
         run_msg(md, en, iv, n, 1'b0);
         compare_model(md, en, iv, n);
         for (int i = 0; i < n; i++) din[i] = got_out[i];
         run_msg(md, ~en, iv, n, 1'b0);
         for (int i = 0; i < n; i++) check("round_trip", got_out[i], pt[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_stream_mode_engine.md
Name: aes_stream_mode_engine

Overview:
Multi-block streaming successor to the single-block AES mode top. It accepts a message of N 128-bit blocks on a valid/ready input stream and applies ECB, CBC, CFB, OFB or CTR chaining in both directions. It drives an external AES core through a start/done handshake and emits results on a valid/ready output stream. The block sits between the DMA-facing stream and the AES round core; the feedback register, counter and mode control are merged into one FSM-controlled datapath.

Parameters:
DATA_W, 128, block width; must equal the core width.
CTR_W, 32, low counter bits incremented in CTR mode (1..DATA_W).
LEN_W, 16, width of the block-count field.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cfg_start  in  1  one-cycle pulse; latches cfg_* and begins a message
cfg_mode  in  3  0 ECB, 1 CBC, 2 CFB, 3 OFB, 4 CTR; 5-7 invalid
cfg_enc_dec  in  1  1 encrypt, 0 decrypt
cfg_iv  in  DATA_W  IV, or initial counter in CTR mode
cfg_num_blocks  in  LEN_W  blocks in the message
s_valid / s_ready  in / out  1  input handshake
s_data  in  DATA_W  input block
m_valid / m_ready  out / in  1  output handshake
m_data  out  DATA_W  result block
m_last  out  1  qualifies the final block of the message
core_start  out  1  one-cycle start pulse to the core
core_enc_dec  out  1  direction presented to the core
core_in  out  DATA_W  core input, registered
core_out  in  DATA_W  core result, valid when core_done=1
core_done  in  1  core completion pulse
busy  out  1  high from accepted cfg_start until msg_done
msg_done  out  1  one-cycle pulse after the last output handshake
err_mode  out  1  sticky invalid-mode flag

Behaviour:
- Reset (asynchronous, low): all outputs 0, FSM in IDLE, chain register and block counter cleared. Reset may occur mid-message; any core_done that arrives afterwards is ignored.
- FSM states: IDLE, ACCEPT, CORE, OUTPUT.
- IDLE:
  - cfg_start with a valid mode: latch mode, direction, chain=cfg_iv and remaining=cfg_num_blocks; clear err_mode; go to ACCEPT.
  - Invalid mode: set err_mode and stay in IDLE.
  - num_blocks=0: pulse msg_done on the next cycle and stay in IDLE.
- cfg_start while busy is ignored.
- ACCEPT: s_ready=1. On handshake, register s_data and core_in. In the following cycle, core_start=1 and the FSM enters CORE.
- CORE: wait for core_done. core_out is captured in that cycle, m_data is registered, and the chain register is updated. m_valid asserts the next cycle in OUTPUT.
- core_done outside CORE is ignored.
- OUTPUT: hold m_valid, m_data and m_last stable until m_ready. On handshake, decrement remaining.
  - remaining=0: pulse msg_done, deassert busy, go to IDLE.
  - Otherwise go to ACCEPT.
- Per-mode datapath (E = core_out, D = input block):
  - ECB: core_in=D; out=E.
  - CBC encrypt: core_in=D^chain; out=E; chain=out.
  - CBC decrypt: core_in=D; out=E^chain; chain=D.
  - CFB: core_in=chain; out=E^D; chain = out when encrypting, D when decrypting.
  - OFB: core_in=chain; out=E^D; chain=E.
  - CTR: core_in=chain; out=E^D; low CTR_W bits of chain increment modulo 2^CTR_W, upper bits unchanged.
- core_enc_dec = cfg_enc_dec for ECB/CBC; forced to 1 for CFB, OFB and CTR.
- Minimum per-block latency from input handshake to m_valid is core latency + 2 cycles. There is no overlap between blocks.

Decomposition:
- Package aes_mode_pkg holds: mode encodings (MODE_ECB..MODE_CTR), the FSM state enum, and DATA_W default.
- One natural sub-module, aes_chain_unit, holds the chain register. It has load-IV, per-mode update and the CTR_W-bit wrapping increment, plus the combinational core_in/out selection.

Test Plan:
Bench core model: E = in ^ all-ones, core_done 2 cycles after core_start.
- ECB encrypt, 1 block, D=0 → core_enc_dec=1, m_data=all-ones, m_last=1, then msg_done pulse, busy=0.
- CBC encrypt, iv=1, blocks 0 and 0 → m_data = FF..FE, then 00..01. CBC decrypt of those two blocks → 0, 0.
- CTR, CTR_W=32, iv=128'h1_FFFFFFFF, 2 blocks → core_in = 128'h1_FFFFFFFF, then 128'h1_00000000 (wrap confined to the low 32 bits).
- Backpressure: m_ready held low 5 cycles → m_data/m_valid stable, s_ready=0, no core_start. cfg_start pulsed while busy → ignored.
- cfg_mode=6 → err_mode=1, busy stays 0. cfg_num_blocks=0 → msg_done pulse one cycle after cfg_start, no s_ready.
- Reset asserted while in CORE → all outputs 0 immediately. A late core_done produces no m_valid; a new message then runs correctly.
